fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter controller for the 9-bit instruction ROM (2**D words). Drives the ROM address each cycle and sequences one program run from a start request to HALT-opcode detection. Resolves next-PC from sequential, relative-branch, absolute-jump and stall inputs supplied by decode/ALU. Counts cycles per run for performance reporting.

Parameters:
D, 12, PC/ROM address width; ROM depth 2**D
START_ADDR, 0, PC value loaded on reset and on each run start (D bits)
HALT_CODE, 9'b111111111, machine code that ends a run
OFS_W, 8, width of signed relative-branch offset
CNT_W, 16, cycle-counter width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  run request; sampled in IDLE or DONE only
mach_code  input  9  instruction word currently read from ROM at prog_ctr
stall  input  1  hold PC this cycle (RUN only)
jump_en  input  1  absolute jump this cycle
jump_target  input  D  absolute jump address
branch_taken  input  1  relative branch this cycle
branch_ofs  input  OFS_W  signed two's-complement offset relative to current PC
prog_ctr  output  D  ROM address (registered)
fetch_valid  output  1  mach_code at prog_ctr belongs to the active run
done  output  1  run complete (registered)
cycle_cnt  output  CNT_W  RUN cycles in current/last run (registered)

Behaviour:
- Clock: single clk; reset is asynchronous and active-low (reset_n); all state flops clear immediately on reset_n=0, independent of clk.
- Reset values: state=IDLE, prog_ctr=START_ADDR, done=0, fetch_valid=0, cycle_cnt=0.
- States: IDLE, RUN, DONE. fetch_valid = (state==RUN), decoded from the state register; done = (state==DONE), a registered flop.
- IDLE: start=1 -> RUN next edge; prog_ctr<=START_ADDR, cycle_cnt<=0. start=0 -> hold.
- RUN, each edge, priority highest first:
  1. mach_code==HALT_CODE -> DONE; prog_ctr holds at halt address; cycle_cnt increments for this cycle.
  2. stall=1 -> prog_ctr holds.
  3. jump_en=1 -> prog_ctr<=jump_target.
  4. branch_taken=1 -> prog_ctr<=prog_ctr + sign_extend(branch_ofs), truncated to D bits (mod 2**D).
  5. else -> prog_ctr<=prog_ctr+1, mod 2**D (2**D-1 wraps to 0).
- cycle_cnt increments by 1 on every RUN edge, including stalled cycles; saturates at 2**CNT_W-1 and does not wrap.
- Halt beats stall/jump/branch in the same cycle. jump_en and branch_taken both high -> jump wins.
- start is ignored while in RUN. stall/jump_en/branch_taken are ignored in IDLE and DONE.
- DONE: prog_ctr and cycle_cnt hold (readable). start=1 -> RUN next edge, prog_ctr<=START_ADDR, cycle_cnt<=0, done falls that edge.
- HALT_CODE at START_ADDR: one RUN cycle, cycle_cnt=1, then DONE.
- reset_n asserted mid-RUN: immediate return to reset values; no run resumes without a new start.
- Latency: prog_ctr changes one edge after the deciding inputs; done rises one edge after halt is seen in RUN.

Test Plan:
- Reset then start=1 for 1 cycle, ROM 0..4 = NOP, addr 5 = HALT -> prog_ctr 0,1,2,3,4,5; done=1 on the edge after addr 5 is seen; cycle_cnt=6; prog_ctr holds 5.
- At PC=3: branch_ofs=-3, branch_taken=1 -> next PC=0. At PC=3: branch_ofs=+10 -> next PC=13. At PC=4094, D=12: ofs=+5 -> next PC=3 (wrap). Sequential step from 4095 -> 0.
- At PC=7: jump_en=1, jump_target=100, branch_taken=1, ofs=2 -> next PC=100. At PC=7: stall=1 with jump_en=1 -> PC holds at 7; cycle_cnt still increments.
- HALT at PC=9 with stall=1 and jump_en=1 asserted -> DONE, prog_ctr=9; start pulses during RUN have no effect.
- From DONE: start=1 -> prog_ctr=0, cycle_cnt=0, done=0 next edge; second run identical to the first.
- reset_n low asynchronously mid-run at PC=20 -> prog_ctr=0, done=0, fetch_valid=0 before the next clk edge; remains in IDLE until start.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC controller that runs the instruction ROM from a start request to a HALT opcode.
module fetch_sequencer #(
    parameter int           D          = 12,
    parameter logic [D-1:0] START_ADDR = '0,
    parameter logic [8:0]   HALT_CODE  = 9'b111111111,
    parameter int           OFS_W      = 8,
    parameter int           CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [8:0]       mach_code,
    input  logic             stall,
    input  logic             jump_en,
    input  logic [D-1:0]     jump_target,
    input  logic             branch_taken,
    input  logic [OFS_W-1:0] branch_ofs,
    output logic [D-1:0]     prog_ctr,
    output logic             fetch_valid,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [D-1:0]     ofs_ext;
    assign ofs_ext = {{(D-OFS_W){branch_ofs[OFS_W-1]}}, branch_ofs};
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (state_q != RUN) begin
            if (start) begin
                state_d = RUN;
                pc_d    = START_ADDR;
                cnt_d   = '0;
                done_d  = 1'b0;
            end
        end else begin
            // counter saturates so a runaway program still reports a sane value
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            if (mach_code == HALT_CODE) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                pc_d = stall        ? pc_q :
                       jump_en      ? jump_target :
                       branch_taken ? pc_q + ofs_ext :
                                      pc_q + D'(1);
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
    assign prog_ctr    = pc_q;
    assign fetch_valid = (state_q == RUN);
    assign done        = done_q;
    assign cycle_cnt   = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer with a behavioural ROM.
module tb_fetch_sequencer;
    localparam logic [8:0] HALT = 9'h1FF;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  mach_code;
    logic        stall = 1'b0;
    logic        jump_en = 1'b0;
    logic [11:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_ofs = '0;
    logic [11:0] prog_ctr;
    logic        fetch_valid;
    logic        done;
    logic [15:0] cycle_cnt;
    logic [8:0]  rom [4096];
    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mach_code(mach_code),
        .stall(stall), .jump_en(jump_en), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_ofs(branch_ofs),
        .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .done(done), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;
    assign mach_code = rom[prog_ctr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_halt5(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_start_pc"}, 32'(prog_ctr), 0);
        chk({tag, "_start_cnt"}, 32'(cycle_cnt), 0);
        chk({tag, "_start_fv"}, 32'(fetch_valid), 1);
        chk({tag, "_start_done"}, 32'(done), 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk({tag, "_seq_pc"}, 32'(prog_ctr), 32'(i));
        end
        step();
        chk({tag, "_halt_done"}, 32'(done), 1);
        chk({tag, "_halt_pc"}, 32'(prog_ctr), 5);
        chk({tag, "_halt_cnt"}, 32'(cycle_cnt), 6);
        chk({tag, "_halt_fv"}, 32'(fetch_valid), 0);
        step();
        chk({tag, "_hold_pc"}, 32'(prog_ctr), 5);
        chk({tag, "_hold_cnt"}, 32'(cycle_cnt), 6);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 9'h000;
        rom[5] = HALT;
        #1;
        chk("rst_pc", 32'(prog_ctr), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fv", 32'(fetch_valid), 0);
        chk("rst_cnt", 32'(cycle_cnt), 0);
        step();
        reset_n = 1'b1;
        step();
        chk("idle_fv", 32'(fetch_valid), 0);
        run_to_halt5("run1");
        run_to_halt5("run2");
        rom[5] = 9'h000;
        rom[9] = HALT;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("pc3_a", 32'(prog_ctr), 3);
        branch_taken = 1'b1; branch_ofs = 8'hFD;
        step();
        branch_taken = 1'b0;
        chk("br_neg3", 32'(prog_ctr), 0);
        repeat (3) step();
        branch_taken = 1'b1; branch_ofs = 8'd10; start = 1'b1;
        step();
        branch_taken = 1'b0; start = 1'b0;
        chk("br_pos10", 32'(prog_ctr), 13);
        jump_en = 1'b1; jump_target = 12'd7;
        step();
        chk("jmp7", 32'(prog_ctr), 7);
        jump_target = 12'd100; branch_taken = 1'b1; branch_ofs = 8'd2;
        step();
        branch_taken = 1'b0;
        chk("jmp_beats_br", 32'(prog_ctr), 100);
        jump_target = 12'd7;
        step();
        stall = 1'b1; jump_target = 12'd100;
        step();
        stall = 1'b0;
        chk("stall_pc", 32'(prog_ctr), 7);
        chk("stall_cnt", 32'(cycle_cnt), 12);
        jump_target = 12'd4094;
        step();
        jump_en = 1'b0;
        branch_taken = 1'b1; branch_ofs = 8'd5;
        step();
        branch_taken = 1'b0;
        chk("br_wrap", 32'(prog_ctr), 3);
        jump_en = 1'b1; jump_target = 12'd4095;
        step();
        jump_en = 1'b0;
        step();
        chk("seq_wrap", 32'(prog_ctr), 0);
        jump_en = 1'b1; jump_target = 12'd9;
        step();
        chk("pc9", 32'(prog_ctr), 9);
        stall = 1'b1; jump_target = 12'd100; start = 1'b1;
        step();
        stall = 1'b0; jump_en = 1'b0; start = 1'b0;
        chk("halt9_done", 32'(done), 1);
        chk("halt9_pc", 32'(prog_ctr), 9);
        chk("halt9_cnt", 32'(cycle_cnt), 18);
        rom[9] = 9'h000;
        rom[0] = HALT;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("h0_fv", 32'(fetch_valid), 1);
        step();
        chk("h0_done", 32'(done), 1);
        chk("h0_cnt", 32'(cycle_cnt), 1);
        chk("h0_pc", 32'(prog_ctr), 0);
        rom[0] = 9'h000;
        start = 1'b1;
        step();
        start = 1'b0;
        jump_en = 1'b1; jump_target = 12'd20;
        step();
        jump_en = 1'b0;
        chk("pc20", 32'(prog_ctr), 20);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_pc", 32'(prog_ctr), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_fv", 32'(fetch_valid), 0);
        chk("arst_cnt", 32'(cycle_cnt), 0);
        #1;
        reset_n = 1'b1;
        repeat (3) step();
        chk("post_rst_fv", 32'(fetch_valid), 0);
        chk("post_rst_pc", 32'(prog_ctr), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
